// File: rtl/key_event_pkg.sv
// Alarm-clock UI package: key FSM state encoding and default press timing (ms).
package key_event_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_REPEAT
  } key_state_e;

  localparam int unsigned KEY_LONG_MS   = 2000;
  localparam int unsigned KEY_REPEAT_MS = 250;

endpackage

// File: rtl/key_event_if.sv
// Button-in / UI-events-out bundle between the debouncer side and the setting FSMs.
interface key_event_if;
  logic i_en;
  logic i_btn;
  logic o_press;
  logic o_release;
  logic o_long_press;
  logic o_rpt;
  logic o_held;

  modport master (
    output i_en, i_btn,
    input  o_press, o_release, o_long_press, o_rpt, o_held
  );

  modport slave (
    input  i_en, i_btn,
    output o_press, o_release, o_long_press, o_rpt, o_held
  );
endinterface

// File: rtl/key_edge.sv
// Button level history and rising-edge decode; history resets to "pressed"
// so a button held through reset never looks like a fresh press.
module key_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_rise
);

  logic r_btn_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_btn_q <= 1'b1;
    else        r_btn_q <= i_btn;
  end

  assign o_rise = i_btn & ~r_btn_q;

endmodule

// File: rtl/key_event.sv
// Turns a debounced button level into press/release/long-press/auto-repeat pulses.
module key_event
  import key_event_pkg::*;
#(
  parameter int unsigned LONG_TICKS   = KEY_LONG_MS,
  parameter int unsigned REPEAT_TICKS = KEY_REPEAT_MS,
  parameter int unsigned CNT_W        = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  key_event_if.slave  kbus
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

  key_state_e       r_state, w_nxt_state;
  logic [CNT_W-1:0] r_cnt, w_nxt_cnt;
  logic             r_press, r_release, r_long, r_rpt, r_held;
  logic             w_press, w_release, w_long, w_rpt;
  logic             w_rise;

  key_edge u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_btn  (kbus.i_btn),
    .o_rise (w_rise)
  );

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_press     = 1'b0;
    w_release   = 1'b0;
    w_long      = 1'b0;
    w_rpt       = 1'b0;
    if (!kbus.i_en) begin
      w_nxt_state = ST_IDLE;
      w_nxt_cnt   = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            w_press     = 1'b1;
            w_nxt_cnt   = '0;
            w_nxt_state = ST_HOLD;
          end
        end
        ST_HOLD: begin
          // Release is checked first so it beats a coincident terminal count.
          if (!kbus.i_btn) begin
            w_release   = 1'b1;
            w_nxt_cnt   = '0;
            w_nxt_state = ST_IDLE;
          end else if (r_cnt == LONG_LAST) begin
            w_long      = 1'b1;
            w_nxt_cnt   = '0;
            w_nxt_state = ST_REPEAT;
          end else begin
            w_nxt_cnt = r_cnt + CNT_W'(1);
          end
        end
        ST_REPEAT: begin
          if (!kbus.i_btn) begin
            w_release   = 1'b1;
            w_nxt_cnt   = '0;
            w_nxt_state = ST_IDLE;
          end else if (r_cnt == REPEAT_LAST) begin
            w_rpt     = 1'b1;
            w_nxt_cnt = '0;
          end else begin
            w_nxt_cnt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_nxt_state = ST_IDLE;
          w_nxt_cnt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      r_rpt     <= 1'b0;
      r_held    <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_cnt     <= w_nxt_cnt;
      r_press   <= w_press;
      r_release <= w_release;
      r_long    <= w_long;
      r_rpt     <= w_rpt;
      r_held    <= (w_nxt_state != ST_IDLE);
    end
  end

  assign kbus.o_press      = r_press;
  assign kbus.o_release    = r_release;
  assign kbus.o_long_press = r_long;
  assign kbus.o_rpt        = r_rpt;
  assign kbus.o_held       = r_held;

endmodule

// File: tb/tb_key_event.sv
// Bench for key_event with LONG_TICKS=4, REPEAT_TICKS=2: directed scenarios
// followed by random button/enable traffic against a hold-age reference model.
module tb_key_event;

  localparam int unsigned LT = 4;
  localparam int unsigned RT = 2;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  key_event_if kbus ();

  key_event #(
    .LONG_TICKS   (LT),
    .REPEAT_TICKS (RT),
    .CNT_W        (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kbus  (kbus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: whether a press is live, how many edges it has been held, last btn seen.
  logic m_active;
  logic m_prev;
  int   m_age;
  logic e_press, e_rel, e_long, e_rpt;
  int   n_rpt_seen;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0b expected %0b at %0t", tag, obs, exp, $time);
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".press"},   kbus.o_press,      e_press);
    chk({tag, ".release"}, kbus.o_release,    e_rel);
    chk({tag, ".long"},    kbus.o_long_press, e_long);
    chk({tag, ".rpt"},     kbus.o_rpt,        e_rpt);
    chk({tag, ".held"},    kbus.o_held,       m_active);
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_prev   = 1'b1;
    m_age    = 0;
    e_press  = 1'b0;
    e_rel    = 1'b0;
    e_long   = 1'b0;
    e_rpt    = 1'b0;
  endtask

  task automatic step(input string tag, input logic b, input logic e);
    @(negedge clk);
    kbus.i_btn = b;
    kbus.i_en  = e;
    @(posedge clk);
    e_press = 1'b0;
    e_rel   = 1'b0;
    e_long  = 1'b0;
    e_rpt   = 1'b0;
    if (!e) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (b && !m_prev) begin
        e_press  = 1'b1;
        m_active = 1'b1;
        m_age    = 0;
      end
    end else if (!b) begin
      e_rel    = 1'b1;
      m_active = 1'b0;
    end else begin
      m_age++;
      if (m_age == LT) e_long = 1'b1;
      else if (m_age > LT && ((m_age - LT) % RT) == 0) e_rpt = 1'b1;
    end
    m_prev = b;
    #1;
    if (kbus.o_rpt === 1'b1) n_rpt_seen++;
    chk_all(tag);
  endtask

  initial begin
    n_chk      = 0;
    n_pass     = 0;
    n_rpt_seen = 0;
    rst_n      = 1'b0;
    kbus.i_btn = 1'b0;
    kbus.i_en  = 1'b1;
    model_reset();
    #12;
    chk_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step("idle0", 1'b0, 1'b1);

    // 1: short press
    for (int i = 0; i < 3; i++) step("short", 1'b1, 1'b1);
    step("short_rel", 1'b0, 1'b1);
    step("short_idle", 1'b0, 1'b1);

    // 2: long hold with two repeats
    n_rpt_seen = 0;
    for (int i = 0; i < 10; i++) step("long", 1'b1, 1'b1);
    step("long_rel", 1'b0, 1'b1);
    chk("long.rpt_count", (n_rpt_seen == 2), 1'b1);
    step("long_idle", 1'b0, 1'b1);

    // 3: release coincident with long-press terminal count
    for (int i = 0; i < 4; i++) step("coinc", 1'b1, 1'b1);
    step("coinc_rel", 1'b0, 1'b1);
    step("coinc_idle", 1'b0, 1'b1);

    // 4: enable drops mid-hold, returns with btn still high
    for (int i = 0; i < 5; i++) step("endrop", 1'b1, 1'b1);
    step("endrop_off", 1'b1, 1'b0);
    step("endrop_off", 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step("endrop_on", 1'b1, 1'b1);
    step("endrop_lo", 1'b0, 1'b1);
    step("endrop_repress", 1'b1, 1'b1);
    step("endrop_rel", 1'b0, 1'b1);

    // 5: held through reset
    @(negedge clk);
    kbus.i_btn = 1'b1;
    rst_n      = 1'b0;
    model_reset();
    #1;
    chk_all("thru_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step("thru_rst_hold", 1'b1, 1'b1);
    step("thru_rst_lo", 1'b0, 1'b1);
    step("thru_rst_press", 1'b1, 1'b1);

    // 6: asynchronous reset mid-REPEAT
    for (int i = 0; i < 6; i++) step("midrep", 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_all("midrep_async");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step("midrep_after", 1'b1, 1'b1);
    step("midrep_lo", 1'b0, 1'b1);

    // Random traffic: variable hold/gap lengths, occasional enable drops
    for (int seg = 0; seg < 60; seg++) begin
      int unsigned len;
      logic        b;
      b   = seg[0];
      len = $urandom_range(1, 12);
      for (int unsigned k = 0; k < len; k++)
        step("rand", b, ($urandom_range(0, 19) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
